// File: rtl/steer_quad_pkg.sv
// rtl/steer_quad_pkg.sv - shared types and phase encoding for the quadrature steering encoder
//
// Purpose: quadrature phase constants, FSM/direction enums and the phase
//          index -> {a,b} lookup shared by steer_quad_ch and steer_quad_multi.
// Ports:   none (package).
package steer_quad_pkg;

  localparam logic [1:0] QPH0 = 2'b00;
  localparam logic [1:0] QPH1 = 2'b01;
  localparam logic [1:0] QPH2 = 2'b11;
  localparam logic [1:0] QPH3 = 2'b10;

  typedef enum logic {ST_IDLE, ST_RUN} steer_st_t;
  typedef enum logic {DIR_L, DIR_R} steer_dir_t;

  // Phase index counts up for right steps and down for left steps, so the
  // Gray-coded {a,b} pair only ever changes one bit per step.
  function automatic logic [1:0] qph_of(input logic [1:0] idx);
    case (idx)
      2'd0:    return QPH0;
      2'd1:    return QPH1;
      2'd2:    return QPH2;
      default: return QPH3;
    endcase
  endfunction

endpackage

// File: rtl/steer_quad_ch.sv
// rtl/steer_quad_ch.sv - one steering channel: request FSM, period counter, accel ramp, phase
//
// Purpose: turns an exclusive left/right request into quadrature steps whose
//          period is clkdiv >> level, with level ramping up while held.
// Ports:   clk_i, resetn_i (sync, active low), clkdiv_i base period,
//          accel_en_i ramp enable, req_l_i/req_r_i decoded requests,
//          a_o/b_o quadrature pair, busy_o high in RUN,
//          pos_o signed wheel position (only with STEER_QUAD_POS_EN).
module steer_quad_ch
  import steer_quad_pkg::*;
#(
  parameter int DIV_W      = 24,
  parameter int ACCEL_LVLS = 4,
  parameter int ACCEL_HOLD = 16
) (
  input  logic             clk_i,
  input  logic             resetn_i,
  input  logic [DIV_W-1:0] clkdiv_i,
  input  logic             accel_en_i,
  input  logic             req_l_i,
  input  logic             req_r_i,
  output logic             a_o,
  output logic             b_o,
  output logic             busy_o
`ifdef STEER_QUAD_POS_EN
  ,
  output logic [7:0]       pos_o
`endif
);

  localparam int STEP_W = (ACCEL_HOLD > 1) ? $clog2(ACCEL_HOLD) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(ACCEL_HOLD - 1);
  localparam logic [2:0]        LVL_TOP   = 3'(ACCEL_LVLS - 1);

  steer_st_t         state_q, state_d;
  steer_dir_t        dir_q, dir_d;
  logic [DIV_W-1:0]  counter_q, counter_d;
  logic [2:0]        level_q, level_d;
  logic [STEP_W-1:0] stepcnt_q, stepcnt_d;
  logic [1:0]        phase_q, phase_d;
`ifdef STEER_QUAD_POS_EN
  logic [7:0]        pos_q, pos_d;
`endif

  logic             req_any;
  steer_dir_t       req_dir;
  logic [DIV_W-1:0] period;
  logic             fire;

  assign req_any = req_l_i | req_r_i;
  assign req_dir = req_r_i ? DIR_R : DIR_L;

  // Greater-or-equal so a shrinking clkdiv (or level step) cannot strand
  // the counter above the new compare value.
  always_comb begin
    period = clkdiv_i >> level_q;
    if (period == '0) period = DIV_W'(1);
    fire = (counter_q >= period - DIV_W'(1));
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (!resetn_i) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req_any)  state_d = ST_RUN;
      ST_RUN:  if (!req_any) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next-state
  always_comb begin
    dir_d     = dir_q;
    counter_d = counter_q;
    level_d   = level_q;
    stepcnt_d = stepcnt_q;
    phase_d   = phase_q;
`ifdef STEER_QUAD_POS_EN
    pos_d     = pos_q;
`endif
    case (state_q)
      ST_RUN: begin
        if (!req_any || (req_dir != dir_q)) begin
          // Release or reversal restarts the ramp without moving the phase.
          dir_d     = req_any ? req_dir : dir_q;
          counter_d = '0;
          level_d   = '0;
          stepcnt_d = '0;
        end else if (fire) begin
          counter_d = '0;
          phase_d   = (dir_q == DIR_R) ? phase_q + 2'd1 : phase_q - 2'd1;
`ifdef STEER_QUAD_POS_EN
          pos_d     = (dir_q == DIR_R) ? pos_q + 8'd1 : pos_q - 8'd1;
`endif
          if (accel_en_i && (level_q != LVL_TOP)) begin
            if (stepcnt_q == STEP_LAST) begin
              level_d   = level_q + 3'd1;
              stepcnt_d = '0;
            end else begin
              stepcnt_d = stepcnt_q + STEP_W'(1);
            end
          end else if (stepcnt_q != STEP_LAST) begin
            stepcnt_d = stepcnt_q + STEP_W'(1);
          end
        end else begin
          counter_d = counter_q + DIV_W'(1);
        end
      end
      default: begin
        counter_d = '0;
        level_d   = '0;
        stepcnt_d = '0;
        if (req_any) dir_d = req_dir;
      end
    endcase
    if (!accel_en_i) level_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      dir_q     <= DIR_L;
      counter_q <= '0;
      level_q   <= '0;
      stepcnt_q <= '0;
      phase_q   <= '0;
`ifdef STEER_QUAD_POS_EN
      pos_q     <= '0;
`endif
    end else begin
      dir_q     <= dir_d;
      counter_q <= counter_d;
      level_q   <= level_d;
      stepcnt_q <= stepcnt_d;
      phase_q   <= phase_d;
`ifdef STEER_QUAD_POS_EN
      pos_q     <= pos_d;
`endif
    end
  end

  // Outputs decode straight from registers, so they are glitch-free.
  always_comb begin
    {a_o, b_o} = qph_of(phase_q);
    busy_o     = (state_q == ST_RUN);
  end

`ifdef STEER_QUAD_POS_EN
  assign pos_o = pos_q;
`endif

endmodule

// File: rtl/steer_quad_multi.sv
// rtl/steer_quad_multi.sv - multi-channel joystick to quadrature steering encoder
//
// Purpose: registers per-player left/right, decodes exclusive requests and
//          drives NUM_CH independent steer_quad_ch channels.
//          Optional macro STEER_QUAD_POS_EN adds the pos output.
// Ports:   CLK, Reset_n (sync, active low), clkdiv base period, accel_en,
//          left/right per-channel requests, steer_a/steer_b quadrature pairs,
//          busy per channel, pos (NUM_CH x signed 8 bit, optional).
module steer_quad_multi
  import steer_quad_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int DIV_W      = 24,
  parameter int ACCEL_LVLS = 4,
  parameter int ACCEL_HOLD = 16
) (
  input  logic              CLK,
  input  logic              Reset_n,
  input  logic [DIV_W-1:0]  clkdiv,
  input  logic              accel_en,
  input  logic [NUM_CH-1:0] left,
  input  logic [NUM_CH-1:0] right,
  output logic [NUM_CH-1:0] steer_a,
  output logic [NUM_CH-1:0] steer_b,
  output logic [NUM_CH-1:0] busy
`ifdef STEER_QUAD_POS_EN
  ,
  output logic [NUM_CH*8-1:0] pos
`endif
);

  logic [NUM_CH-1:0] left_q, right_q;

  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      left_q  <= '0;
      right_q <= '0;
    end else begin
      left_q  <= left;
      right_q <= right;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    // Both or neither pressed decodes to no request.
    steer_quad_ch #(
      .DIV_W      (DIV_W),
      .ACCEL_LVLS (ACCEL_LVLS),
      .ACCEL_HOLD (ACCEL_HOLD)
    ) u_ch (
      .clk_i      (CLK),
      .resetn_i   (Reset_n),
      .clkdiv_i   (clkdiv),
      .accel_en_i (accel_en),
      .req_l_i    (left_q[g] & ~right_q[g]),
      .req_r_i    (right_q[g] & ~left_q[g]),
      .a_o        (steer_a[g]),
      .b_o        (steer_b[g]),
      .busy_o     (busy[g])
`ifdef STEER_QUAD_POS_EN
      ,
      .pos_o      (pos[g*8 +: 8])
`endif
    );
  end

endmodule

// File: tb/tb_steer_quad_multi.sv
// tb/tb_steer_quad_multi.sv - self-checking bench for steer_quad_multi
module tb_steer_quad_multi;

  localparam int NUM_CH     = 4;
  localparam int DIV_W      = 24;
  localparam int ACCEL_LVLS = 4;
  localparam int ACCEL_HOLD = 16;

  logic              CLK = 1'b0;
  logic              Reset_n;
  logic [DIV_W-1:0]  clkdiv;
  logic              accel_en;
  logic [NUM_CH-1:0] left, right;
  logic [NUM_CH-1:0] steer_a, steer_b, busy;
`ifdef STEER_QUAD_POS_EN
  logic [NUM_CH*8-1:0] pos;
`endif

  steer_quad_multi #(
    .NUM_CH(NUM_CH), .DIV_W(DIV_W), .ACCEL_LVLS(ACCEL_LVLS), .ACCEL_HOLD(ACCEL_HOLD)
  ) dut (
    .CLK(CLK), .Reset_n(Reset_n), .clkdiv(clkdiv), .accel_en(accel_en),
    .left(left), .right(right),
    .steer_a(steer_a), .steer_b(steer_b), .busy(busy)
`ifdef STEER_QUAD_POS_EN
    , .pos(pos)
`endif
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: wheel position as an index into the Gray sequence,
  // a wait of "elapsed cycles since RUN entry / last step" against P.
  logic [1:0] abtbl [4];
  bit  m_run [NUM_CH];
  bit  m_right [NUM_CH];
  int  m_el [NUM_CH];
  int  m_lvl [NUM_CH];
  int  m_held [NUM_CH];
  int  m_ph [NUM_CH];
  logic [7:0] m_pos [NUM_CH];
  logic [NUM_CH-1:0] m_lq, m_rq;

  task automatic model_edge();
    if (!Reset_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        m_run[c] = 0; m_right[c] = 0; m_el[c] = 0; m_lvl[c] = 0;
        m_held[c] = 0; m_ph[c] = 0; m_pos[c] = 8'd0;
      end
      m_lq = '0; m_rq = '0;
      return;
    end
    for (int c = 0; c < NUM_CH; c++) begin
      bit want_r, want_l;
      int p;
      want_r = m_rq[c] && !m_lq[c];
      want_l = m_lq[c] && !m_rq[c];
      if (!m_run[c]) begin
        if (want_r || want_l) begin
          m_run[c] = 1; m_right[c] = want_r; m_el[c] = 0;
        end
        m_lvl[c] = 0; m_held[c] = 0;
      end else if (!(want_r || want_l)) begin
        m_run[c] = 0; m_el[c] = 0; m_lvl[c] = 0; m_held[c] = 0;
      end else if (want_r != m_right[c]) begin
        m_right[c] = want_r; m_el[c] = 0; m_lvl[c] = 0; m_held[c] = 0;
      end else begin
        m_el[c]++;
        p = int'(clkdiv >> m_lvl[c]);
        if (p < 1) p = 1;
        if (m_el[c] >= p) begin
          m_el[c] = 0;
          m_ph[c] = (m_ph[c] + (m_right[c] ? 1 : 3)) % 4;
          m_pos[c] = m_right[c] ? m_pos[c] + 8'd1 : m_pos[c] - 8'd1;
          if (accel_en && m_lvl[c] < ACCEL_LVLS - 1) begin
            if (m_held[c] == ACCEL_HOLD - 1) begin
              m_lvl[c]++; m_held[c] = 0;
            end else m_held[c]++;
          end else if (m_held[c] < ACCEL_HOLD - 1) m_held[c]++;
        end
      end
      if (!accel_en) m_lvl[c] = 0;
    end
    m_lq = left; m_rq = right;
  endtask

  task automatic tick();
    logic [NUM_CH-1:0] ea, eb, ebusy;
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    for (int c = 0; c < NUM_CH; c++) begin
      {ea[c], eb[c]} = abtbl[m_ph[c]];
      ebusy[c] = m_run[c];
    end
    check("steer_a", 64'(steer_a), 64'(ea));
    check("steer_b", 64'(steer_b), 64'(eb));
    check("busy", 64'(busy), 64'(ebusy));
`ifdef STEER_QUAD_POS_EN
    begin
      logic [NUM_CH*8-1:0] epos;
      for (int c = 0; c < NUM_CH; c++) epos[c*8 +: 8] = m_pos[c];
      check("pos", 64'(pos), 64'(epos));
    end
`endif
  endtask

  function automatic logic [1:0] ab(input int c);
    return {steer_a[c], steer_b[c]};
  endfunction

  int times[$];
  logic [1:0] vals[$];

  initial begin
    logic [1:0] prev;
    int exp_t;
    int sh;
    abtbl[0] = 2'b00; abtbl[1] = 2'b01; abtbl[2] = 2'b11; abtbl[3] = 2'b10;
    Reset_n = 1'b0; left = '0; right = '0; clkdiv = 24'd10; accel_en = 1'b0;
    repeat (5) tick();
    check("rst_busy", 64'(busy), 64'd0);
    Reset_n = 1'b1;
    repeat (100) tick();
    check("idle_ab", 64'({steer_a, steer_b}), 64'd0);

    // Fixed rate, right on channel 0
    right[0] = 1'b1;
    for (int k = 0; k <= 41; k++) begin
      tick();
      if (k == 10) check("r0_k10", 64'(ab(0)), 64'(2'b00));
      if (k == 11) check("r0_k11", 64'(ab(0)), 64'(2'b01));
      if (k == 21) check("r0_k21", 64'(ab(0)), 64'(2'b11));
      if (k == 31) check("r0_k31", 64'(ab(0)), 64'(2'b10));
      if (k == 41) check("r0_k41", 64'(ab(0)), 64'(2'b00));
      if (k == 41) check("r0_others", 64'({steer_a[3:1], steer_b[3:1]}), 64'd0);
    end
    right[0] = 1'b0;
    repeat (5) tick();

    // Acceleration ramp, left on channel 1
    clkdiv = 24'd64; accel_en = 1'b1; left[1] = 1'b1;
    prev = ab(1);
    for (int k = 0; k < 1895; k++) begin
      tick();
      if (ab(1) != prev) begin
        times.push_back(k); vals.push_back(ab(1)); prev = ab(1);
      end
    end
    check("acc_count", 64'(times.size()), 64'd60);
    exp_t = 65;
    for (int n = 1; n <= 60 && n <= times.size(); n++) begin
      if (n > 1) begin
        sh = (n - 1) / 16;
        if (sh > 3) sh = 3;
        exp_t += 64 >> sh;
      end
      check($sformatf("acc_t%0d", n), 64'(times[n-1]), 64'(exp_t));
      check($sformatf("acc_v%0d", n), 64'(vals[n-1]), 64'(abtbl[(4 - n % 4) % 4]));
    end
    left[1] = 1'b0;
    repeat (5) tick();

    // Direction reversal on channel 2
    right[2] = 1'b1;
    for (int k = 0; k <= 270; k++) begin
      tick();
      if (k == 193) check("rev_k193", 64'(ab(2)), 64'(2'b10));
      if (k == 200) begin right[2] = 1'b0; left[2] = 1'b1; end
      if (k == 202) check("rev_busy", 64'(busy[2]), 64'd1);
      if (k == 202) check("rev_k202", 64'(ab(2)), 64'(2'b10));
      if (k == 265) check("rev_k265", 64'(ab(2)), 64'(2'b10));
      if (k == 266) check("rev_k266", 64'(ab(2)), 64'(2'b11));
    end
    left[2] = 1'b0;
    repeat (5) tick();

    // Both pressed, then clkdiv=0 single-cycle stepping on channel 3
    clkdiv = 24'd0; left[3] = 1'b1; right[3] = 1'b1;
    repeat (20) tick();
    check("both_busy", 64'(busy[3]), 64'd0);
    check("both_ab", 64'(ab(3)), 64'd0);
    left[3] = 1'b0;
    for (int k = 0; k <= 5; k++) begin
      tick();
      if (k == 1) check("fast_k1", 64'(ab(3)), 64'(2'b00));
      if (k == 2) check("fast_k2", 64'(ab(3)), 64'(2'b01));
      if (k == 3) check("fast_k3", 64'(ab(3)), 64'(2'b11));
      if (k == 4) check("fast_k4", 64'(ab(3)), 64'(2'b10));
      if (k == 5) check("fast_k5", 64'(ab(3)), 64'(2'b00));
    end
    right[3] = 1'b0;
    repeat (3) tick();

    // Random stimulus against the model
    for (int i = 0; i < 3000; i++) begin
      if (i % 256 == 0) begin
        clkdiv = DIV_W'($urandom_range(0, 24));
        accel_en = 1'($urandom_range(0, 1));
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if ($urandom_range(0, 63) == 0) left[c] = ~left[c];
        if ($urandom_range(0, 63) == 0) right[c] = ~right[c];
      end
      tick();
    end
    left = '0; right = '0;
    repeat (5) tick();

`ifdef STEER_QUAD_POS_EN
    Reset_n = 1'b0; tick(); Reset_n = 1'b1;
    clkdiv = 24'd0; accel_en = 1'b0; right[0] = 1'b1;
    for (int k = 0; k <= 131; k++) begin
      tick();
      if (k == 131) check("pos_130", 64'(pos[7:0]), 64'(8'h82));
    end
    Reset_n = 1'b0;
    tick();
    check("pos_rst", 64'(pos), 64'd0);
    check("ab_rst", 64'(ab(0)), 64'd0);
    Reset_n = 1'b1; right = '0;
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/steer_quad_multi.md
Name: steer_quad_multi

Overview:
- Multi-channel successor to the single-wheel joystick-to-quadrature steering encoder.
- Converts per-player digital left/right into Atari-style quadrature A/B pairs for up to NUM_CH steering wheels (Sprint 2/4/8 class boards).
- Adds a per-channel acceleration ramp: rate increases while a direction is held.
- Sits between the MiSTer joystick/keyboard merge logic and the game core's SteerA/SteerB inputs, on the core video-rate clock.

Parameters:
- NUM_CH, 4, number of independent steering channels (1..8).
- DIV_W, 24, width of the base period divider input.
- ACCEL_LVLS, 4, number of rate levels (1..8); level L uses period clkdiv>>L.
- ACCEL_HOLD, 16, quadrature steps emitted at one level before moving up a level.

Ports:
- CLK  in  1  core clock; all logic is on its rising edge.
- Reset_n  in  1  synchronous active-low reset.
- clkdiv  in  DIV_W  base step period in CLK cycles; sampled every cycle.
- accel_en  in  1  1 = acceleration ramp enabled; 0 = fixed level 0.
- left  in  NUM_CH  per-channel steer-left request, active high.
- right  in  NUM_CH  per-channel steer-right request, active high.
- steer_a  out  NUM_CH  quadrature phase A per channel.
- steer_b  out  NUM_CH  quadrature phase B per channel.
- busy  out  NUM_CH  1 while the channel is in RUN state.

Behaviour:
- Reset (Reset_n=0 at a clock edge): steer_a=0, steer_b=0, busy=0; all counters, levels and step counts are 0; state is IDLE. Reset mid-run abandons the phase and returns {a,b}=00.
- Input stage: left/right are registered once, giving 1 cycle of input latency. Requests are decoded as: dir_r = right & ~left; dir_l = left & ~right. Both or neither pressed means no request.
- Phase sequence {a,b}:
  - Right steps forward through 00→01→11→10→00.
  - Left steps backward through 00→10→11→01→00.
  - Phase is held in a 2-bit index and wraps mod 4.
- Per-channel FSM:
  - IDLE: counter=0, level=0, stepcnt=0. On a decoded request → RUN, latch direction, counter=0.
  - RUN:
    - counter increments each cycle.
    - When counter == P-1: advance one phase in the latched direction, counter←0, stepcnt+1.
    - No request → IDLE, phase held.
    - Opposite request → stays RUN with the new direction; counter, level and stepcnt are cleared; the phase is not advanced on that cycle.
- Period: P = clkdiv >> level, clamped to a minimum of 1. clkdiv=0 behaves as 1, i.e. one step per cycle. A clkdiv change takes effect at the next counter compare. There is no mid-count reload, but a compare against a smaller P fires when counter ≥ P-1.
- Acceleration:
  - Only when accel_en=1.
  - When stepcnt reaches ACCEL_HOLD-1 and a step fires: level←min(level+1, ACCEL_LVLS-1), stepcnt←0.
  - At the top level, stepcnt saturates and is ignored.
  - accel_en falling: level←0 on the next cycle.
- First step timing: P cycles after RUN entry, i.e. P+1 cycles after the raw input edge.
- Channels are fully independent; there is no shared arbitration.
- busy equals (state==RUN), registered.

Optional Feature:
- Macro: STEER_QUAD_POS_EN.
- When defined:
  - Adds output pos, width NUM_CH*8: a signed 8-bit wheel position per channel.
  - Increments on each right step, decrements on each left step, wrapping at ±128 (two's complement).
  - Reset to 0.
  - Used by cores that read wheel position directly instead of decoding quadrature.
- When undefined: the port and counters are absent. Quadrature behaviour is identical either way.

Decomposition:
- Package steer_quad_pkg:
  - Phase encoding constants QPH0..QPH3 = 2'b00, 2'b01, 2'b11, 2'b10.
  - typedef enum {ST_IDLE, ST_RUN} steer_st_t.
  - typedef enum {DIR_L, DIR_R} steer_dir_t.
- Sub-module steer_quad_ch: one channel (FSM, counter, level, phase), instantiated NUM_CH times in a generate loop. The top level holds only the input registers and port packing.

Test Plan:
- Reset hold, then release with no inputs → all steer_a/b=0 and busy=0 for 100 cycles.
- clkdiv=10, accel_en=0, right[0] held → {a,b}[0] goes 01,11,10,00 at cycles 11,21,31,41 after the edge; other channels stay 00.
- clkdiv=64, ACCEL_HOLD=16, accel_en=1, left[1] held → first 16 steps 64 cycles apart, next 16 steps 32 apart, then 16, then 8 steady; sequence is 10,11,01,00.
- Direction reversal: right[2] held for 3 steps, then right→left in one cycle → no step that cycle; next step goes backward 64 cycles later; level is back to 0.
- left and right both high on ch3 → busy=0 and phase frozen; clkdiv=0 with right → one phase step per cycle.
- With STEER_QUAD_POS_EN defined: 130 right steps → pos[0] reads -126; Reset_n low mid-run → pos=0, {a,b}=00 next cycle.
